// File: rtl/demux1_16_reg_if.sv
// Bus bundle for demux1_16_reg: producer handshake, slot outputs and consumer acks.
// DEMUX_BCAST_EN adds the in_bcast broadcast request.
interface demux1_16_reg_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
);
    localparam int N = 2 ** SEL_W;

    logic [WIDTH-1:0]   in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] out_data;
    logic [N-1:0]       out_valid;
    logic [N-1:0]       out_ack;
    logic [SEL_W:0]     occupancy;
`ifdef DEMUX_BCAST_EN
    logic               in_bcast;

    modport master (output in_data, in_sel, in_valid, in_bcast, out_ack,
                    input  in_ready, out_data, out_valid, occupancy);
    modport slave  (input  in_data, in_sel, in_valid, in_bcast, out_ack,
                    output in_ready, out_data, out_valid, occupancy);
`else
    modport master (output in_data, in_sel, in_valid, out_ack,
                    input  in_ready, out_data, out_valid, occupancy);
    modport slave  (input  in_data, in_sel, in_valid, out_ack,
                    output in_ready, out_data, out_valid, occupancy);
`endif
endinterface

// File: rtl/demux1_16_reg.sv
// Registered 1-to-N distributor: steers a word into one of N held slots, each
// released by its consumer ack. DEMUX_BCAST_EN enables loading all slots at once.
module demux1_16_reg #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    demux1_16_reg_if.slave  bus
);
    localparam int N = 2 ** SEL_W;

    logic [N*WIDTH-1:0] data_q,  data_d;
    logic [N-1:0]       valid_q, valid_d;
    logic [SEL_W:0]     occ_q,   occ_d;
    logic               ready_s;
    logic               accept_s;
    logic               bcast_acc_s;
    logic               fill_empty_s;
    logic [N-1:0]       load_s;
    logic [N-1:0]       clear_s;

    function automatic logic [SEL_W:0] popcnt(input logic [N-1:0] v);
        logic [SEL_W:0] c;
        c = {(SEL_W+1){1'b0}};
        for (int i = 0; i < N; i++) begin
            c = c + {{SEL_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Producer back-pressure: a slot is free if empty or being drained this cycle.
    always_comb begin
        ready_s = 1'b0;
`ifdef DEMUX_BCAST_EN
        if (bus.in_bcast) begin
            ready_s = (occ_q == {(SEL_W+1){1'b0}});
        end else begin
            ready_s = ~valid_q[bus.in_sel] | bus.out_ack[bus.in_sel];
        end
`else
        ready_s = ~valid_q[bus.in_sel] | bus.out_ack[bus.in_sel];
`endif
    end

    // Next-state: slot loads, ack clears (a same-slot accept wins) and occupancy.
    always_comb begin
        accept_s = bus.in_valid & ready_s;
`ifdef DEMUX_BCAST_EN
        bcast_acc_s = accept_s & bus.in_bcast;
`else
        bcast_acc_s = 1'b0;
`endif
        load_s = {N{1'b0}};
        if (bcast_acc_s) begin
            load_s = {N{1'b1}};
        end else if (accept_s) begin
            load_s[bus.in_sel] = 1'b1;
        end else begin
            load_s = {N{1'b0}};
        end

        if (bcast_acc_s) begin
            clear_s = {N{1'b0}};
        end else begin
            clear_s = valid_q & bus.out_ack & ~load_s;
        end

        valid_d = (valid_q & ~clear_s) | load_s;

        data_d = data_q;
        for (int k = 0; k < N; k++) begin
            if (load_s[k]) begin
                data_d[k*WIDTH +: WIDTH] = bus.in_data;
            end else begin
                data_d[k*WIDTH +: WIDTH] = data_q[k*WIDTH +: WIDTH];
            end
        end

        fill_empty_s = accept_s & ~valid_q[bus.in_sel];
        if (bcast_acc_s) begin
            occ_d = (SEL_W+1)'(N);
        end else begin
            occ_d = occ_q + {{SEL_W{1'b0}}, fill_empty_s} - popcnt(clear_s);
        end
    end

    // Slot storage, valid flags and occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= {(N*WIDTH){1'b0}};
            valid_q <= {N{1'b0}};
            occ_q   <= {(SEL_W+1){1'b0}};
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.occupancy = occ_q;

endmodule
